isq_oldest_select: RTL

// - Dequeue/select stage directly downstream of the issue-queue entry array.
// - Each cycle, picks the oldest entry whose ready_to_dequeue is high.
// - Captures that entry into a registered issue slot and pulses clear_entry to
//   the same entry, so that entry frees in the following cycle.
// - Drives the execution unit through a valid/ready handshake; flush drops the

---
 rtl/isq_oldest_select.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/isq_oldest_select.sv
// isq_oldest_select: oldest-ready pick from the issue-queue entry array.
// A combinational tournament tree finds the oldest entry with ready_to_dequeue
// set; the winner is captured into a single registered issue slot and told to
// free itself through a one-hot clear_entry pulse in the same cycle.
//
// Issue handshake (valid/ready): issue_valid stays high and issue_data,
// issue_index and issue_slot stay stable until a cycle with issue_ready high;
// that cycle is the accept. A new pick may be captured in the accept cycle,
// giving one uop per cycle. flush drops the held uop without counting it.
module isq_oldest_select #(
    parameter int NUM_ENTRIES = 8,
    parameter int DATA_WIDTH  = 64,
    parameter int INDEX_WIDTH = 7,
    localparam int SLOT_WIDTH = $clog2(NUM_ENTRIES)
) (
    input  logic                               clock,
    input  logic                               reset_n,
    input  logic                               flush,
    input  logic [NUM_ENTRIES-1:0]             entry_ready,
    input  logic [NUM_ENTRIES*DATA_WIDTH-1:0]  entry_data,
    input  logic [NUM_ENTRIES*INDEX_WIDTH-1:0] entry_index,
    output logic [NUM_ENTRIES-1:0]             clear_entry,
    output logic                               issue_valid,
    input  logic                               issue_ready,
    output logic [DATA_WIDTH-1:0]              issue_data,
    output logic [INDEX_WIDTH-1:0]             issue_index,
    output logic [SLOT_WIDTH-1:0]              issue_slot,
    output logic [31:0]                        issue_count
);

    // Tree nodes are heap-numbered: node 1 is the root, node k has children
    // 2k (lower slots) and 2k+1 (higher slots), leaves are NUM_ENTRIES..2N-1.
    localparam int NODES = 2 * NUM_ENTRIES;

    logic                   node_valid [1:NODES-1];
    logic [INDEX_WIDTH-1:0] node_index [1:NODES-1];
    logic [SLOT_WIDTH-1:0]  node_slot  [1:NODES-1];

    logic                   any_ready;
    logic [SLOT_WIDTH-1:0]  win_slot;
    logic [INDEX_WIDTH-1:0] win_index;
    logic [DATA_WIDTH-1:0]  win_data;
    logic                   load;
    logic                   accept;

    logic                   issue_valid_q, issue_valid_d;
    logic [DATA_WIDTH-1:0]  issue_data_q,  issue_data_d;
    logic [INDEX_WIDTH-1:0] issue_index_q, issue_index_d;
    logic [SLOT_WIDTH-1:0]  issue_slot_q,  issue_slot_d;
    logic [31:0]            issue_count_q, issue_count_d;

    // Wrap-aware age compare: same wrap flag means the smaller ROB position
    // is older; differing flags mean the larger position has not yet wrapped.
    function automatic logic is_older(input logic [INDEX_WIDTH-1:0] a,
                                      input logic [INDEX_WIDTH-1:0] b);
        logic                   fa, fb;
        logic [INDEX_WIDTH-2:0] pa, pb;
        fa = a[INDEX_WIDTH-1];
        fb = b[INDEX_WIDTH-1];
        pa = a[INDEX_WIDTH-2:0];
        pb = b[INDEX_WIDTH-2:0];
        return (fa == fb) ? (pa < pb) : (pa > pb);
    endfunction

    // Tournament tree: fill leaves, then resolve pairs bottom-up; the right
    // child only wins when strictly older, so ties go to the lower slot.
    always_comb begin
        for (int s = 0; s < NUM_ENTRIES; s++) begin
            node_valid[NUM_ENTRIES+s] = entry_ready[s];
            node_index[NUM_ENTRIES+s] = entry_index[s*INDEX_WIDTH +: INDEX_WIDTH];
            node_slot[NUM_ENTRIES+s]  = SLOT_WIDTH'(s);
        end
        for (int k = NUM_ENTRIES - 1; k >= 1; k--) begin
            if (node_valid[2*k+1] &&
                (!node_valid[2*k] || is_older(node_index[2*k+1], node_index[2*k]))) begin
                node_valid[k] = 1'b1;
                node_index[k] = node_index[2*k+1];
                node_slot[k]  = node_slot[2*k+1];
            end else begin
                node_valid[k] = node_valid[2*k];
                node_index[k] = node_index[2*k];
                node_slot[k]  = node_slot[2*k];
            end
        end
    end

    assign any_ready = node_valid[1];
    assign win_slot  = node_slot[1];
    assign win_index = node_index[1];
    assign win_data  = entry_data[win_slot*DATA_WIDTH +: DATA_WIDTH];

    assign accept = issue_valid_q && issue_ready;
    assign load   = !flush && any_ready && (!issue_valid_q || issue_ready);

    // One-hot clear to the captured entry; silent whenever nothing is loaded.
    always_comb begin
        clear_entry = '0;
        if (load) begin
            clear_entry[win_slot] = 1'b1;
        end
    end

    // Next-state for the issue slot and the issued-uop counter.
    always_comb begin
        issue_valid_d = issue_valid_q;
        issue_data_d  = issue_data_q;
        issue_index_d = issue_index_q;
        issue_slot_d  = issue_slot_q;
        issue_count_d = issue_count_q;
        if (flush) begin
            issue_valid_d = 1'b0;
        end else if (load) begin
            issue_valid_d = 1'b1;
            issue_data_d  = win_data;
            issue_index_d = win_index;
            issue_slot_d  = win_slot;
        end else if (accept) begin
            issue_valid_d = 1'b0;
        end
        if (accept && !flush) begin
            issue_count_d = issue_count_q + 32'd1;
        end
    end

    // Issue-slot registers with asynchronous active-low reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            issue_valid_q <= 1'b0;
            issue_data_q  <= '0;
            issue_index_q <= '0;
            issue_slot_q  <= '0;
            issue_count_q <= '0;
        end else begin
            issue_valid_q <= issue_valid_d;
            issue_data_q  <= issue_data_d;
            issue_index_q <= issue_index_d;
            issue_slot_q  <= issue_slot_d;
            issue_count_q <= issue_count_d;
        end
    end

    assign issue_valid = issue_valid_q;
    assign issue_data  = issue_data_q;
    assign issue_index = issue_index_q;
    assign issue_slot  = issue_slot_q;
    assign issue_count = issue_count_q;

endmodule
